// File: rtl/ov7670_pkg.sv
// Shared types and defaults for the OV7670 capture path.
//   capture_state_t : capture FSM states
//   rgb565_t        : one RGB565 pixel, first camera byte in [15:8]
//   pixel_word_t    : FIFO entry, pixel plus start-of-frame / end-of-line tags
package ov7670_pkg;

   typedef enum logic [1:0] {
      IDLE,
      VBLANK,
      ACTIVE
   } capture_state_t;

   typedef logic [15:0] rgb565_t;

   typedef struct packed {
      logic    sof;
      logic    eol;
      rgb565_t rgb;
   } pixel_word_t;

   localparam int unsigned PIXEL_WORD_W = $bits(pixel_word_t);
   localparam int unsigned DEF_H_PIXELS = 320;
   localparam int unsigned DEF_V_LINES  = 240;

endpackage

// File: rtl/ov7670_pixel_capture_fifo.sv
// Synchronous show-ahead FIFO of packed pixel words.
//   clk, reset : system clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and word; accepted when not full, or when full
//                with a pop in the same cycle
//   full       : DEPTH entries held
//   pop        : consume the word on dout (ignored when empty)
//   dout       : oldest entry, valid whenever empty is low
//   empty      : no entries held
module pixel_fifo
   import ov7670_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [PIXEL_WORD_W-1:0] din,
   output logic                    full,
   input  logic                    pop,
   output logic [PIXEL_WORD_W-1:0] dout,
   output logic                    empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [PIXEL_WORD_W-1:0] mem_q [DEPTH];
   logic [AW:0]             wr_ptr_d, wr_ptr_q;
   logic [AW:0]             rd_ptr_d, rd_ptr_q;
   logic                    wr_en;
   logic                    rd_en;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en = pop & ~empty;
   // When full, the slot being written is the one being read out this cycle.
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: oversamples pclk/href/vsync/data in the clk
// domain, pairs bytes into RGB565 pixels tagged with sof/eol, and buffers
// them behind a valid/ready stream.
//   clk, reset        : system clock (>= 4x pclk), synchronous active-high reset
//   vsync, href, pclk : camera timing, asynchronous, all oversampled
//   cam_data          : camera byte, synchronised with the same depth
//   pixel_data/sof/eol: stream word, held while valid & ~ready
//   pixel_valid/ready : stream handshake, transfer when both high
//   frame_active      : capture FSM in ACTIVE
//   line_count        : lines completed in the current frame (saturates)
//   overflow          : sticky, a pixel was dropped on a full FIFO
//   line_error        : sticky, bad line length, odd byte count or bad line total
module ov7670_pixel_capture
   import ov7670_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned H_PIXELS    = DEF_H_PIXELS,
   parameter int unsigned V_LINES     = DEF_V_LINES,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        href,
   input  logic        pclk,
   input  logic [7:0]  cam_data,
   output logic [15:0] pixel_data,
   output logic        pixel_sof,
   output logic        pixel_eol,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        frame_active,
   output logic [8:0]  line_count,
   output logic        overflow,
   output logic        line_error
);

   localparam int unsigned  PCW     = $clog2(H_PIXELS + 1) + 1;
   localparam logic [PCW-1:0] H_LAST  = PCW'(H_PIXELS - 1);
   localparam logic [PCW-1:0] H_TOTAL = PCW'(H_PIXELS);
   localparam logic [8:0]     V_TOTAL = 9'(V_LINES);

   // Synchroniser chain, one 11-bit lane {vsync, href, pclk, data} per stage
   logic [SYNC_STAGES-1:0][10:0] sync_d, sync_q;
   logic [2:0]     edge_d, edge_q;
   logic           vsync_s, href_s, pclk_s;
   logic [7:0]     data_s;
   logic           pclk_rise, href_fall, vsync_rise, vsync_fall;

   capture_state_t state_d, state_q;
   logic           phase_d, phase_q;
   logic [7:0]     hi_d, hi_q;
   logic [PCW-1:0] pix_cnt_d, pix_cnt_q;
   logic [8:0]     line_cnt_d, line_cnt_q;
   logic           sof_arm_d, sof_arm_q;
   logic           push_d, push_q;
   pixel_word_t    word_d, word_q;
   logic           overflow_d, overflow_q;
   logic           line_err_d, line_err_q;

   logic           fifo_full, fifo_empty, fifo_pop;
   pixel_word_t    fifo_dout;

   assign vsync_s = sync_q[SYNC_STAGES-1][10];
   assign href_s  = sync_q[SYNC_STAGES-1][9];
   assign pclk_s  = sync_q[SYNC_STAGES-1][8];
   assign data_s  = sync_q[SYNC_STAGES-1][7:0];

   assign pclk_rise  = pclk_s & ~edge_q[0];
   assign href_fall  = ~href_s & edge_q[1];
   assign vsync_rise = vsync_s & ~edge_q[2];
   assign vsync_fall = ~vsync_s & edge_q[2];

   assign fifo_pop = ~fifo_empty & pixel_ready;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], {vsync, href, pclk, cam_data}};
      edge_d = {vsync_s, href_s, pclk_s};
   end

   // Capture and line bookkeeping look at state_q, so a vsync edge landing
   // on the same cycle as a capture changes state only on the next cycle.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      hi_d       = hi_q;
      pix_cnt_d  = pix_cnt_q;
      line_cnt_d = line_cnt_q;
      sof_arm_d  = sof_arm_q;
      push_d     = 1'b0;
      word_d     = word_q;
      overflow_d = overflow_q;
      line_err_d = line_err_q;

      if (state_q == ACTIVE && pclk_rise && href_s) begin
         if (!phase_q) begin
            hi_d    = data_s;
            phase_d = 1'b1;
         end else begin
            phase_d    = 1'b0;
            push_d     = 1'b1;
            word_d.sof = sof_arm_q;
            word_d.eol = (pix_cnt_q == H_LAST);
            word_d.rgb = {hi_q, data_s};
            // Disarmed even if this pixel is later dropped on overflow.
            sof_arm_d  = 1'b0;
            if (pix_cnt_q >= H_TOTAL) line_err_d = 1'b1;
            if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end

      if (state_q == ACTIVE && href_fall) begin
         if (phase_q) line_err_d = 1'b1;
         if (pix_cnt_q != H_TOTAL) line_err_d = 1'b1;
         phase_d   = 1'b0;
         pix_cnt_d = '0;
         if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (vsync_rise) state_d = VBLANK;
         end
         VBLANK: begin
            if (vsync_fall) begin
               state_d    = ACTIVE;
               line_cnt_d = '0;
               pix_cnt_d  = '0;
               phase_d    = 1'b0;
               sof_arm_d  = 1'b1;
            end
         end
         ACTIVE: begin
            if (vsync_rise) begin
               state_d = VBLANK;
               if (line_cnt_q != V_TOTAL) line_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push_q && fifo_full && !fifo_pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q     <= '0;
         edge_q     <= '0;
         state_q    <= IDLE;
         phase_q    <= 1'b0;
         hi_q       <= '0;
         pix_cnt_q  <= '0;
         line_cnt_q <= '0;
         sof_arm_q  <= 1'b0;
         push_q     <= 1'b0;
         word_q     <= '0;
         overflow_q <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         edge_q     <= edge_d;
         state_q    <= state_d;
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         pix_cnt_q  <= pix_cnt_d;
         line_cnt_q <= line_cnt_d;
         sof_arm_q  <= sof_arm_d;
         push_q     <= push_d;
         word_q     <= word_d;
         overflow_q <= overflow_d;
         line_err_q <= line_err_d;
      end
   end

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .din   (word_q),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   // Stale FIFO storage is masked so the stream reads all-zero when idle.
   assign pixel_valid  = ~fifo_empty;
   assign pixel_data   = fifo_empty ? '0 : fifo_dout.rgb;
   assign pixel_sof    = ~fifo_empty & fifo_dout.sof;
   assign pixel_eol    = ~fifo_empty & fifo_dout.eol;
   assign frame_active = (state_q == ACTIVE);
   assign line_count   = line_cnt_q;
   assign overflow     = overflow_q;
   assign line_error   = line_err_q;

endmodule
